// File: rtl/ov7670_pkg.sv
// Shared OV7670 capture definitions: sequencer states, byte order and default frame geometry
// used by the capture, frame-buffer and VGA readout blocks.
package ov7670_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FRAME = 2'd2,
        DONE  = 2'd3
    } cap_state_e;

    // The first byte of each RGB565 pair lands in wr_data[15:8].
    localparam bit HI_FIRST = 1'b1;

    localparam int H_PIX_DEF   = 320;
    localparam int V_LINES_DEF = 240;
    localparam int ADDR_W_DEF  = 17;

endpackage

// File: rtl/ov7670_capture_ctrl_if.sv
// Frame-buffer write port: one strobe per pixel with a linear address and RGB565 data.
interface ov7670_capture_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/ov7670_byte_pair.sv
// Pairs consecutive camera bytes into one 16-bit pixel; flags a line that ends on a half pixel.
module ov7670_byte_pair
    import ov7670_pkg::*;
(
    input  logic        pclk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        line_end,
    input  logic [7:0]  din,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        odd_at_end
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;

    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        if (clr || line_end) begin
            phase_d = 1'b0;
        end else if (en) begin
            phase_d = ~phase_q;
            if (!phase_q) hi_d = din;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

    assign pix_valid  = en & phase_q;
    assign pix_data   = HI_FIRST ? {hi_q, din} : {din, hi_q};
    assign odd_at_end = line_end & phase_q;

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 frame-capture sequencer: arms, waits for VSYNC fall, writes RGB565 pixels linearly.
// Define CAPTURE_DECIMATE_EN for 2:1 decimation on both axes.
module ov7670_capture_ctrl
    import ov7670_pkg::*;
#(
    parameter int H_PIX   = H_PIX_DEF,
    parameter int V_LINES = V_LINES_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
)(
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [7:0]            din,
    input  logic                  cap_start,
    input  logic                  cap_cont,
    input  logic                  cap_abort,
    ov7670_capture_ctrl_if.master fb,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  frame_short,
    output logic                  line_err
);

    localparam int COL_W  = $clog2(H_PIX + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);
`ifdef CAPTURE_DECIMATE_EN
    localparam int STRIDE = H_PIX / 2;
`else
    localparam int STRIDE = H_PIX;
`endif

    logic       vsync_q, vsync_p_q, href_q, href_p_q;
    logic [7:0] din_q;

    cap_state_e        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d, busy_q, busy_d;
    logic              frame_short_q, frame_short_d, line_err_q, line_err_d;

    logic        in_frame, vs_fall, vs_rise, hr_fall, line_full, col_ok, base_step;
    logic        pix_valid, odd_at_end;
    logic [15:0] pix_data;

    assign in_frame  = (state_q == FRAME);
    assign vs_fall   = vsync_p_q & ~vsync_q;
    assign vs_rise   = ~vsync_p_q & vsync_q;
    assign hr_fall   = href_p_q & ~href_q;
    assign line_full = hr_fall && (line_q == LINE_W'(V_LINES - 1));

`ifdef CAPTURE_DECIMATE_EN
    assign col_ok    = (col_q < COL_W'(H_PIX)) && !col_q[0] && !line_q[0];
    assign base_step = line_q[0];
`else
    assign col_ok    = (col_q < COL_W'(H_PIX));
    assign base_step = 1'b1;
`endif

    ov7670_byte_pair u_pair (
        .pclk       (pclk),
        .reset      (reset),
        .clr        (!in_frame || cap_abort),
        .en         (in_frame && href_q),
        .line_end   (in_frame && hr_fall),
        .din        (din_q),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .odd_at_end (odd_at_end)
    );

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        line_d        = line_q;
        addr_d        = addr_q;
        base_d        = base_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_short_d = frame_short_q;
        line_err_d    = line_err_q;

        unique case (state_q)
            IDLE: if (cap_start) begin
                state_d       = ARMED;
                frame_short_d = 1'b0;
                line_err_d    = 1'b0;
            end
            ARMED: if (vs_fall) state_d = FRAME;
            FRAME: begin
                if (pix_valid && col_ok) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = pix_data;
                    addr_d    = addr_q + 1'b1;
                end
                if (pix_valid && (col_q < COL_W'(H_PIX))) col_d = col_q + 1'b1;
                // Jump to the next line base so short lines leave a gap, not a shift.
                if (hr_fall) begin
                    col_d  = '0;
                    line_d = line_q + 1'b1;
                    if (base_step) base_d = base_q + ADDR_W'(STRIDE);
                    addr_d = base_d;
                    if (odd_at_end) line_err_d = 1'b1;
                end
                if (line_full || vs_rise) begin
                    state_d = DONE;
                    if (!line_full) frame_short_d = 1'b1;
                end
            end
            DONE:    state_d = cap_cont ? ARMED : IDLE;
            default: state_d = IDLE;
        endcase

        if (cap_abort) begin
            state_d = IDLE;
            wr_en_d = 1'b0;
        end
        if (state_d != FRAME) begin
            col_d  = '0;
            line_d = '0;
            addr_d = '0;
            base_d = '0;
        end
        frame_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            vsync_q       <= 1'b0;
            vsync_p_q     <= 1'b0;
            href_q        <= 1'b0;
            href_p_q      <= 1'b0;
            din_q         <= '0;
            state_q       <= IDLE;
            col_q         <= '0;
            line_q        <= '0;
            addr_q        <= '0;
            base_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_short_q <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            vsync_q       <= vsync;
            vsync_p_q     <= vsync_q;
            href_q        <= href;
            href_p_q      <= href_q;
            din_q         <= din;
            state_q       <= state_d;
            col_q         <= col_d;
            line_q        <= line_d;
            addr_q        <= addr_d;
            base_q        <= base_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            frame_short_q <= frame_short_d;
            line_err_q    <= line_err_d;
        end
    end

    assign fb.wr_en    = wr_en_q;
    assign fb.wr_addr  = wr_addr_q;
    assign fb.wr_data  = wr_data_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;
    assign frame_short = frame_short_q;
    assign line_err    = line_err_q;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed bench for ov7670_capture_ctrl with a 4x3 frame; byte value of line l, byte j is 8*l+j.
module tb_ov7670_capture_ctrl;
    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic [7:0] din = 8'h00;
    logic       cap_start = 1'b0;
    logic       cap_cont = 1'b0;
    logic       cap_abort = 1'b0;
    logic       frame_done, busy, frame_short, line_err;

    ov7670_capture_ctrl_if #(.ADDR_W(AW)) fb_if ();

    ov7670_capture_ctrl #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .pclk        (pclk),
        .reset       (reset),
        .vsync       (vsync),
        .href        (href),
        .din         (din),
        .cap_start   (cap_start),
        .cap_cont    (cap_cont),
        .cap_abort   (cap_abort),
        .fb          (fb_if),
        .frame_done  (frame_done),
        .busy        (busy),
        .frame_short (frame_short),
        .line_err    (line_err)
    );

    always #5 pclk = ~pclk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_done = 0;
    int          busy_low = 0;
    bit          watch_busy = 1'b0;
    logic [19:0] wq[$];

    always @(negedge pclk) begin
        if (fb_if.wr_en) wq.push_back({fb_if.wr_addr, fb_if.wr_data});
        if (frame_done) n_done++;
        if (watch_busy && !busy) busy_low++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic start_cap();
        cap_start = 1'b1;
        cyc();
        cap_start = 1'b0;
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        cyc(3);
        vsync = 1'b0;
        cyc(3);
    endtask

    task automatic send_line(input int l, input int n);
        href = 1'b1;
        for (int j = 0; j < n; j++) begin
            din = 8'(8 * l + j);
            cyc();
        end
        href = 1'b0;
        din  = 8'h00;
        cyc(4);
    endtask

    // Expected writes of line l with n bytes, starting at queue index idx.
    task automatic check_line(input string tag, input int l, input int n, inout int idx);
        int          npix;
        logic [19:0] got, exp;
        npix = (n / 2 < H) ? n / 2 : H;
        for (int k = 0; k < npix; k++) begin
            got = (idx < wq.size()) ? wq[idx] : 20'hFFFFF;
            exp = {4'(l * H + k), 8'(8 * l + 2 * k), 8'(8 * l + 2 * k + 1)};
            check($sformatf("%s l%0d p%0d", tag, l, k), 32'(got), 32'(exp));
            idx++;
        end
    endtask

    function automatic logic [31:0] status();
        return {28'd0, busy, frame_done, frame_short, line_err};
    endfunction

    int d0, idx, snap;

    initial begin
        cyc(3);
        check("reset status", status(), 32'h0);
        check("reset wr_en", 32'(fb_if.wr_en), 32'h0);
        reset = 1'b0;
        cyc(2);
        check("idle status", status(), 32'h0);
        check("idle wr_addr/data", {12'd0, fb_if.wr_addr, fb_if.wr_data}, 32'h0);

        // Full frame, 3 lines x 8 bytes.
        d0 = n_done;
        start_cap();
        check("armed busy", 32'(busy), 32'h1);
        frame_start();
        send_line(0, 8); send_line(1, 8); send_line(2, 8);
        cyc(3);
        check("full count", wq.size(), 32'd12);
        idx = 0;
        check_line("full", 0, 8, idx); check_line("full", 1, 8, idx); check_line("full", 2, 8, idx);
        check("full done", n_done - d0, 32'd1);
        check("full status", status(), 32'h0);

        // Short line 1 leaves a gap; line 2 starts at its own base.
        wq.delete(); d0 = n_done;
        start_cap(); frame_start();
        send_line(0, 8); send_line(1, 4); send_line(2, 8);
        cyc(3);
        check("shortln count", wq.size(), 32'd10);
        idx = 0;
        check_line("shortln", 0, 8, idx); check_line("shortln", 1, 4, idx); check_line("shortln", 2, 8, idx);
        check("shortln wr5", 32'(wq[5]), {12'd0, 4'd5, 16'h0A0B});
        check("shortln wr6", 32'(wq[6]), {12'd0, 4'd8, 16'h1011});
        check("shortln done", n_done - d0, 32'd1);
        check("shortln status", status(), 32'h0);

        // Odd line and long line.
        wq.delete();
        start_cap(); frame_start();
        send_line(0, 7); send_line(1, 12); send_line(2, 8);
        cyc(3);
        check("oddlong count", wq.size(), 32'd11);
        idx = 0;
        check_line("oddlong", 0, 7, idx); check_line("oddlong", 1, 12, idx); check_line("oddlong", 2, 8, idx);
        check("oddlong status", status(), 32'h1);

        // Early vsync with continuous capture, then a full re-armed frame.
        wq.delete(); d0 = n_done;
        cap_cont = 1'b1;
        start_cap(); frame_start();
        send_line(0, 8); send_line(1, 8);
        vsync = 1'b1;
        watch_busy = 1'b1;
        cyc(4);
        check("early count", wq.size(), 32'd8);
        check("early done", n_done - d0, 32'd1);
        check("early status", status(), 32'h a);
        frame_start();
        send_line(0, 8); send_line(1, 8); send_line(2, 8);
        cyc(3);
        watch_busy = 1'b0;
        check("cont count", wq.size(), 32'd20);
        idx = 8;
        check_line("cont", 0, 8, idx); check_line("cont", 1, 8, idx); check_line("cont", 2, 8, idx);
        check("cont done", n_done - d0, 32'd2);
        check("cont status", status(), 32'h a);
        check("cont busy gaps", busy_low, 32'd0);
        cap_cont  = 1'b0;
        cap_abort = 1'b1;
        cyc();
        cap_abort = 1'b0;
        check("abort armed busy", 32'(busy), 32'h0);

        // Abort mid-line while a pixel is being formed.
        wq.delete(); d0 = n_done;
        start_cap(); frame_start();
        send_line(0, 8);
        href = 1'b1;
        din = 8'd8;  cyc();
        din = 8'd9;  cyc();
        din = 8'd10; cap_abort = 1'b1; cyc();
        cap_abort = 1'b0;
        snap = wq.size();
        check("abort busy", 32'(busy), 32'h0);
        for (int j = 3; j < 8; j++) begin
            din = 8'(8 + j);
            cyc();
        end
        href = 1'b0;
        cyc(4);
        send_line(2, 8);
        vsync = 1'b1;
        cyc(4);
        check("abort no writes", wq.size(), 32'(snap));
        check("abort no done", n_done - d0, 32'd0);
        check("abort busy end", 32'(busy), 32'h0);
        idx = 0;
        check_line("abort", 0, 8, idx);

        // Reset in the middle of a frame.
        wq.delete();
        start_cap(); frame_start();
        href = 1'b1;
        for (int j = 0; j < 5; j++) begin
            din = 8'(j);
            cyc();
        end
        reset = 1'b1;
        #2;
        check("midrst status", status(), 32'h0);
        check("midrst wr", {11'd0, fb_if.wr_en, fb_if.wr_addr, fb_if.wr_data}, 32'h0);
        snap = wq.size();
        cyc();
        reset = 1'b0;
        for (int j = 5; j < 8; j++) begin
            din = 8'(j);
            cyc();
        end
        href = 1'b0;
        cyc(4);
        frame_start();
        send_line(0, 8);
        cyc(3);
        check("midrst no writes", wq.size(), 32'(snap));
        check("midrst idle", status(), 32'h0);
        wq.delete(); d0 = n_done;
        start_cap(); frame_start();
        send_line(0, 8); send_line(1, 8); send_line(2, 8);
        cyc(3);
        check("rearm count", wq.size(), 32'd12);
        idx = 0;
        check_line("rearm", 0, 8, idx); check_line("rearm", 1, 8, idx); check_line("rearm", 2, 8, idx);
        check("rearm done", n_done - d0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
